// File: rtl/fp_normalizer_pipe_if.sv
// Handshake bundle for fp_normalizer_pipe: input beat side and result side.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carried as plain valid/ready pairs.
// Ports (slave = normaliser view):
//   in_valid/in_ready/in_sub/significand/exponent_in   upstream beat
//   out_valid/out_ready/significand_out/exponent_out/neg_out/zero_out/uflow_out/shift_out   result
interface fp_normalizer_pipe_if #(
  parameter int SIGNIF_WIDTH = 25,
  parameter int EXP_WIDTH    = 8,
  parameter int SHIFT_WIDTH  = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sub;
  logic [SIGNIF_WIDTH-1:0] significand;
  logic [EXP_WIDTH-1:0]    exponent_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [SIGNIF_WIDTH-1:0] significand_out;
  logic [EXP_WIDTH-1:0]    exponent_out;
  logic                    neg_out;
  logic                    zero_out;
  logic                    uflow_out;
  logic [SHIFT_WIDTH-1:0]  shift_out;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_sub, significand, exponent_in, out_ready,
    input  in_ready, out_valid, significand_out, exponent_out,
           neg_out, zero_out, uflow_out, shift_out
  );

  // Normaliser side.
  modport slave (
    input  in_valid, in_sub, significand, exponent_in, out_ready,
    output in_ready, out_valid, significand_out, exponent_out,
           neg_out, zero_out, uflow_out, shift_out
  );
endinterface

// File: rtl/fp_normalizer_pipe.sv
// Purpose: normalise a raw add/sub significand (magnitude recovery, generic LZC, clamped left shift).
// Latency: 2 cycles from accepted input to out_valid when not stalled; 1 beat/cycle throughput.
// Backpressure: full valid/ready; in_ready is combinational from out_ready, up to 2 beats held.
// Ports: clk, rst_n (async active-low); bus (slave modport of fp_normalizer_pipe_if).
// SHIFT_WIDTH must satisfy 2**SHIFT_WIDTH > SIGNIF_WIDTH so a full-width count fits.
module fp_normalizer_pipe #(
  parameter int SIGNIF_WIDTH = 25,
  parameter int EXP_WIDTH    = 8,
  parameter int SHIFT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_normalizer_pipe_if.slave   bus
);

  // Common width for the exponent-versus-count comparison and subtraction.
  localparam int CMP_W = (EXP_WIDTH > SHIFT_WIDTH) ? EXP_WIDTH : SHIFT_WIDTH;
  localparam logic [SIGNIF_WIDTH-1:0] ONE = {{(SIGNIF_WIDTH-1){1'b0}}, 1'b1};

  // Stage enables: a stage may load when empty or when its successor moves.
  logic w_en1, w_en2;

  // Stage 1 combinational results
  logic                    w_neg;
  logic [SIGNIF_WIDTH-1:0] w_mag;
  logic [SHIFT_WIDTH-1:0]  w_lzc;

  // Stage 1 registers
  logic                    r_v1;
  logic [SIGNIF_WIDTH-1:0] r_mag;
  logic [SHIFT_WIDTH-1:0]  r_lzc;
  logic [EXP_WIDTH-1:0]    r_exp1;
  logic                    r_neg1;

  // Stage 2 combinational results
  logic [CMP_W-1:0]        w_exp_ext;
  logic [CMP_W-1:0]        w_lzc_ext;
  logic                    w_zero;
  logic                    w_uflow;
  logic [SHIFT_WIDTH-1:0]  w_shift;
  logic [EXP_WIDTH-1:0]    w_exp2;
  logic [SIGNIF_WIDTH-1:0] w_sig2;

  // Stage 2 (output) registers
  logic                    r_v2;
  logic [SIGNIF_WIDTH-1:0] r_sig_o;
  logic [EXP_WIDTH-1:0]    r_exp_o;
  logic                    r_neg_o;
  logic                    r_zero_o;
  logic                    r_uflow_o;
  logic [SHIFT_WIDTH-1:0]  r_shift_o;

  assign w_en2 = !r_v2 || bus.out_ready;
  assign w_en1 = !r_v1 || w_en2;

  // Only a subtraction result with its top bit set is treated as negative.
  assign w_neg = bus.in_sub && bus.significand[SIGNIF_WIDTH-1];
  assign w_mag = w_neg ? (~bus.significand + ONE) : bus.significand;

  // Leading-zero count: the highest set bit wins because it is visited last.
  always_comb begin
    w_lzc = SHIFT_WIDTH'(SIGNIF_WIDTH);
    for (int i = 0; i < SIGNIF_WIDTH; i++) begin
      if (w_mag[i]) w_lzc = SHIFT_WIDTH'(SIGNIF_WIDTH - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_mag  <= '0;
      r_lzc  <= '0;
      r_exp1 <= '0;
      r_neg1 <= 1'b0;
    end else begin
      if (w_en1) r_v1 <= bus.in_valid;
      if (w_en1 && bus.in_valid) begin
        r_mag  <= w_mag;
        r_lzc  <= w_lzc;
        r_exp1 <= bus.exponent_in;
        r_neg1 <= w_neg;
      end
    end
  end

  assign w_exp_ext = CMP_W'(r_exp1);
  assign w_lzc_ext = CMP_W'(r_lzc);

  // Shift by the full count if the exponent can absorb it; otherwise shift
  // only by the exponent and clamp it to zero (denormal result).
  always_comb begin
    w_zero  = (r_mag == '0);
    w_uflow = 1'b0;
    w_shift = '0;
    w_exp2  = '0;
    if (w_zero) begin
      w_uflow = 1'b0;
    end else if (w_exp_ext > w_lzc_ext) begin
      w_shift = r_lzc;
      w_exp2  = EXP_WIDTH'(w_exp_ext - w_lzc_ext);
    end else begin
      // exponent <= count <= SIGNIF_WIDTH here, so it fits the shift field.
      w_shift = SHIFT_WIDTH'(w_exp_ext);
      w_uflow = 1'b1;
    end
    w_sig2 = r_mag << w_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2      <= 1'b0;
      r_sig_o   <= '0;
      r_exp_o   <= '0;
      r_neg_o   <= 1'b0;
      r_zero_o  <= 1'b0;
      r_uflow_o <= 1'b0;
      r_shift_o <= '0;
    end else begin
      if (w_en2) r_v2 <= r_v1;
      if (w_en2 && r_v1) begin
        r_sig_o   <= w_sig2;
        r_exp_o   <= w_exp2;
        r_neg_o   <= r_neg1;
        r_zero_o  <= w_zero;
        r_uflow_o <= w_uflow;
        r_shift_o <= w_shift;
      end
    end
  end

  assign bus.in_ready        = w_en1;
  assign bus.out_valid       = r_v2;
  assign bus.significand_out = r_sig_o;
  assign bus.exponent_out    = r_exp_o;
  assign bus.neg_out         = r_neg_o;
  assign bus.zero_out        = r_zero_o;
  assign bus.uflow_out       = r_uflow_o;
  assign bus.shift_out       = r_shift_o;

endmodule
